// File: rtl/pwm_ramp_gen.sv
// Soft-start/soft-stop duty sequencer feeding a PWM clear threshold.
// Latency: duty updates on the edge sampling a qualifying period_end_i; done_o one cycle after the final update.
// Backpressure: none; start_i is accepted only in IDLE, and abort_i returns to IDLE with the duty held.
module pwm_ramp_gen #(
    parameter int               WIDTH      = 8,
    parameter int               DIV_WIDTH  = 8,
    parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
    input  logic                 clk,
    input  logic                 res_ni,
    input  logic                 period_end_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [WIDTH-1:0]     target_i,
    input  logic [WIDTH-1:0]     step_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic [WIDTH-1:0]     duty_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     duty_q, duty_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic [WIDTH-1:0]     step_q, step_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                 busy_q, done_q;
    logic [WIDTH-1:0]     step_eff, up_gap, dn_gap, duty_step;

    // A zero step would stall the ramp forever, so it behaves as a step of one.
    always_comb begin
        step_eff = (step_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step_q;
        up_gap   = target_q - duty_q;
        dn_gap   = duty_q - target_q;
        if (duty_q < target_q) begin
            duty_step = (up_gap <= step_eff) ? target_q : duty_q + step_eff;
        end else begin
            duty_step = (dn_gap <= step_eff) ? target_q : duty_q - step_eff;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        div_d    = div_q;
        pcnt_d   = pcnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    target_d = target_i;
                    step_d   = step_i;
                    div_d    = div_i;
                    pcnt_d   = '0;
                    state_d  = RAMP;
                end
            end
            RAMP: begin
                // Abort wins over a coincident step; arrival at target is seen one cycle late.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (duty_q == target_q) begin
                    state_d = DONE;
                end else if (period_end_i) begin
                    if (pcnt_q == div_q) begin
                        pcnt_d = '0;
                        duty_d = duty_step;
                    end else begin
                        pcnt_d = pcnt_q + DIV_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            state_q  <= IDLE;
            duty_q   <= RESET_DUTY;
            target_q <= '0;
            step_q   <= '0;
            div_q    <= '0;
            pcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            div_q    <= div_d;
            pcnt_q   <= pcnt_d;
            busy_q   <= (state_d == RAMP);
            done_q   <= (state_d == DONE);
        end
    end

    assign duty_o = duty_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Directed bench for pwm_ramp_gen: table of ramps plus abort and mid-ramp reset sequences.
module tb_pwm_ramp_gen;

    localparam int GAP = 15;

    logic       clk = 1'b0;
    logic       res_ni;
    logic       period_end_i;
    logic       start_i;
    logic       abort_i;
    logic [7:0] target_i;
    logic [7:0] step_i;
    logic [7:0] div_i;
    logic [7:0] duty_o;
    logic       busy_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;
    int model_duty = 0;

    typedef struct {
        int              target;
        int              step;
        int              div;
        int              n;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [8];

    pwm_ramp_gen #(.WIDTH(8), .DIV_WIDTH(8), .RESET_DUTY(8'd0)) dut (
        .clk          (clk),
        .res_ni       (res_ni),
        .period_end_i (period_end_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .target_i     (target_i),
        .step_i       (step_i),
        .div_i        (div_i),
        .duty_o       (duty_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_pe(input logic ab);
        period_end_i = 1'b1;
        abort_i      = ab;
        tick();
        period_end_i = 1'b0;
        abort_i      = 1'b0;
    endtask

    task automatic do_ramp(input int t, input int s, input int d, input int n,
                           input logic [3:0][7:0] exp, input string tag);
        target_i = 8'(t);
        step_i   = 8'(s);
        div_i    = 8'(d);
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        // Stale inputs after acceptance must not affect the ramp.
        target_i = ~8'(t);
        step_i   = 8'hff;
        div_i    = 8'd0;
        chk({tag, "_busy_start"}, int'(busy_o), 1);
        chk({tag, "_duty_start"}, int'(duty_o), model_duty);
        for (int k = 0; k < n; k++) begin
            for (int p = 0; p <= d; p++) begin
                pulse_pe(1'b0);
                if (p < d) begin
                    chk({tag, "_hold"}, int'(duty_o), model_duty);
                end else begin
                    model_duty = int'(exp[k]);
                    chk({tag, "_step"}, int'(duty_o), model_duty);
                end
                chk({tag, "_busy_mid"}, int'(busy_o), 1);
                chk({tag, "_done_mid"}, int'(done_o), 0);
                if (!(k == n - 1 && p == d)) repeat (GAP) tick();
            end
        end
        // done_o one cycle after the final update; a start during DONE is dropped.
        start_i  = 1'b1;
        target_i = 8'd7;
        tick();
        start_i  = 1'b0;
        chk({tag, "_done_pulse"}, int'(done_o), 1);
        chk({tag, "_busy_done"}, int'(busy_o), 0);
        chk({tag, "_duty_final"}, int'(duty_o), t);
        tick();
        chk({tag, "_done_clear"}, int'(done_o), 0);
        chk({tag, "_busy_idle"}, int'(busy_o), 0);
        repeat (3) tick();
    endtask

    initial begin
        vecs[0] = '{target:100, step:30,  div:0, n:4, exp:{8'd100, 8'd90,  8'd60, 8'd30}};
        vecs[1] = '{target:10,  step:40,  div:2, n:3, exp:{8'd0,   8'd10,  8'd20, 8'd60}};
        vecs[2] = '{target:50,  step:40,  div:0, n:1, exp:{8'd0,   8'd0,   8'd0,  8'd50}};
        vecs[3] = '{target:50,  step:5,   div:3, n:0, exp:{8'd0,   8'd0,   8'd0,  8'd0}};
        vecs[4] = '{target:0,   step:255, div:1, n:1, exp:{8'd0,   8'd0,   8'd0,  8'd0}};
        vecs[5] = '{target:3,   step:0,   div:0, n:3, exp:{8'd0,   8'd3,   8'd2,  8'd1}};
        vecs[6] = '{target:255, step:200, div:0, n:2, exp:{8'd0,   8'd0,   8'd255, 8'd203}};
        vecs[7] = '{target:0,   step:100, div:0, n:3, exp:{8'd0,   8'd0,   8'd55, 8'd155}};

        res_ni = 1'b0;
        period_end_i = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        target_i = 8'd0;
        step_i = 8'd0;
        div_i = 8'd0;
        #12;
        chk("rst_duty", int'(duty_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        res_ni = 1'b1;
        tick();
        // Abort while idle is a no-op.
        abort_i = 1'b1;
        pulse_pe(1'b1);
        chk("idle_abort_busy", int'(busy_o), 0);
        chk("idle_abort_duty", int'(duty_o), 0);

        for (int i = 0; i < 8; i++) begin
            do_ramp(vecs[i].target, vecs[i].step, vecs[i].div, vecs[i].n,
                    vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Abort coinciding with the fifth qualifying period end.
        target_i = 8'd200;
        step_i   = 8'd10;
        div_i    = 8'd0;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pulse_pe(1'b0);
            model_duty = 10 * k;
            chk("abort_ramp_step", int'(duty_o), model_duty);
            repeat (GAP) tick();
        end
        pulse_pe(1'b1);
        chk("abort_duty_held", int'(duty_o), 40);
        chk("abort_busy", int'(busy_o), 0);
        tick();
        chk("abort_no_done", int'(done_o), 0);
        pulse_pe(1'b0);
        chk("abort_idle_hold", int'(duty_o), 40);
        do_ramp(50, 10, 0, 1, {8'd0, 8'd0, 8'd0, 8'd50}, "post_abort");

        // Asynchronous reset in the middle of a ramp.
        target_i = 8'd120;
        step_i   = 8'd20;
        div_i    = 8'd0;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        pulse_pe(1'b0);
        chk("pre_rst_duty", int'(duty_o), 70);
        #2;
        res_ni = 1'b0;
        #1;
        chk("async_rst_duty", int'(duty_o), 0);
        chk("async_rst_busy", int'(busy_o), 0);
        repeat (2) tick();
        res_ni = 1'b1;
        model_duty = 0;
        for (int k = 0; k < 3; k++) begin
            pulse_pe(1'b0);
            repeat (2) tick();
            chk("post_rst_idle_duty", int'(duty_o), 0);
            chk("post_rst_idle_busy", int'(busy_o), 0);
        end
        do_ramp(5, 5, 0, 1, {8'd0, 8'd0, 8'd0, 8'd5}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_gen.md
Name: pwm_ramp_gen

Overview:
- Soft-start/soft-stop duty sequencer. Sits directly upstream of the PWM generator and drives its clear-threshold (duty) input.
- Moves the duty value from its current setting to a commanded target in bounded steps.
- Takes one step every (div+1) PWM periods, using the PWM period-end pulse as its time base.
- Avoids abrupt duty jumps on motor, LED and similar loads.

Parameters:
- WIDTH, 8, width of duty/target/step values (matches PWM threshold width).
- DIV_WIDTH, 8, width of the periods-per-step divider.
- RESET_DUTY, 0, value of duty_o after reset.

Ports:
- clk  input  1  clock.
- res_ni  input  1  reset, asynchronous, active-low.
- period_end_i  input  1  one-cycle pulse, once per PWM period (counter reload event).
- start_i  input  1  one-cycle request to begin a ramp; sampled only in IDLE.
- abort_i  input  1  level or pulse; stops an active ramp.
- target_i  input  WIDTH  destination duty value, captured on accepted start.
- step_i  input  WIDTH  increment/decrement per step, captured on accepted start.
- div_i  input  DIV_WIDTH  step every div_i+1 periods, captured on accepted start.
- duty_o  output  WIDTH  registered duty value for the PWM clear threshold.
- busy_o  output  1  high while in RAMP.
- done_o  output  1  one-cycle pulse when the ramp reaches its target.

Behaviour:
- Reset (asynchronous, res_ni low, any time including mid-ramp):
  - duty_o=RESET_DUTY, busy_o=0, done_o=0, state=IDLE.
  - Internal target/step/div/period counter cleared to 0.
- States: IDLE, RAMP, DONE.
- IDLE:
  - busy_o=0. duty_o holds its value.
  - On start_i=1: capture target_q, step_q, div_q. Clear period counter pcnt. Next state RAMP.
  - abort_i in IDLE has no effect.
- RAMP:
  - busy_o=1 from the cycle after the accepted start.
  - If duty_o==target_q on entry (zero-length ramp), the next cycle goes to DONE with no duty change.
  - On period_end_i=1:
    - If pcnt==div_q: pcnt<=0 and take a step.
    - Otherwise pcnt<=pcnt+1.
    - Cycles without period_end_i leave pcnt and duty_o unchanged.
  - Step rules (effective step s = max(step_q,1); step_q==0 is treated as 1):
    - duty_o<target_q: if target_q-duty_o <= s then duty_o<=target_q, else duty_o<=duty_o+s.
    - duty_o>target_q: if duty_o-target_q <= s then duty_o<=target_q, else duty_o<=duty_o-s.
    - Arithmetic is unsigned WIDTH-bit. It never overshoots and never wraps (final step clamps to target).
  - When a step makes duty_o equal target_q, the next state is DONE.
  - abort_i=1 has priority over a step in the same cycle: next state IDLE, duty_o holds its current (pre-step) value, no done_o.
  - start_i is ignored in RAMP. Target changes on target_i are ignored until the next accepted start.
- DONE:
  - Lasts exactly one cycle: done_o=1, busy_o=0, then IDLE.
  - start_i during DONE is ignored. abort_i during DONE has no effect.
- Latency:
  - duty_o updates on the clock edge that samples the qualifying period_end_i.
  - done_o asserts one cycle after the final duty update.
  - The first step occurs on the (div_q+1)-th period_end_i after start.
- done_o and busy_o are registered (glitch-free).

Test Plan:
- Reset, then start with target=100, step=30, div=0, pulsing period_end_i every 16 clocks -> duty_o sequence 0,30,60,90,100; busy_o high throughout; done_o single pulse one cycle after reaching 100; busy_o=0 afterwards.
- From duty=100, start target=10, step=40, div=2 -> duty_o changes only on every 3rd period_end_i: 60,20,10 (clamped); done_o pulse.
- start with target equal to current duty (50->50) -> no duty change, done_o pulses 2 cycles after start, busy_o high 1 cycle.
- step_i=0, target=3 from 0, div=0 -> duty_o 1,2,3 (step treated as 1); done_o pulse.
- Ramp 0->200 step 10; assert abort_i in the same cycle as the 5th period_end_i -> duty_o stays 40, state IDLE, no done_o; a new start_i is then accepted.
- Assert res_ni low mid-ramp (duty=70) -> duty_o=RESET_DUTY, busy_o=0 immediately (asynchronously); after release, period_end_i pulses cause no change until start_i.
